sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
SHA-256 message-schedule expander. It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream and emits the full schedule W[0..ROUNDS-1] on a second valid/ready stream, one word per round. It sits directly downstream of the block loader and directly upstream of the compression-round CFU. Internally it performs the sigma0/sigma1 expansion, so the round stage receives W[t] ready to add.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 17..64.
RW, 6, width of the round index; must satisfy 2**RW >= ROUNDS.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  message word available
in_ready  output  1  word accepted when in_valid && in_ready
in_data  input  32  message word M[t], t = 0..15 in order
out_valid  output  1  schedule word available
out_ready  input  1  consumer accepts when out_valid && out_ready
out_data  output  32  W[t]
out_round  output  RW  t for the word on out_data
out_last  output  1  high with W[ROUNDS-1]
busy  output  1  high from first word accepted until last word handed off

Behaviour:
- Reset: state=LOAD, t=0, out_valid=0, out_data=0, out_round=0, out_last=0, busy=0. The 16x32 word buffer is not cleared. A synchronous reset mid-block discards the partial block and any pending output word.
- Storage: a 16-entry circular buffer buf[0..15] indexed by t[3:0], plus a 1-word output register (out_data, out_round, out_last, out_valid).
- slot_free = !out_valid || out_ready. The output register loads only when slot_free; otherwise it holds all fields stable. out_valid must not drop without a handshake.
- State LOAD (t < 16):
  - in_ready = slot_free.
  - On accept: buf[t[3:0]] <= in_data; output register <= {in_data, t, 0}; out_valid <= 1; t <= t+1; busy <= 1.
  - After t=15 is accepted, the state moves to EXPAND.
- State EXPAND (16 <= t < ROUNDS):
  - in_ready = 0.
  - When slot_free: W = sig1(buf[(t-2)&15]) + buf[(t-7)&15] + sig0(buf[(t-15)&15]) + buf[t&15], summed mod 2^32. The last term is W[t-16].
  - Then buf[t&15] <= W; output register <= {W, t, t==ROUNDS-1}; out_valid <= 1; t <= t+1.
  - One word is produced per cycle when the consumer is not stalled.
- Function definitions:
  - sig0(x) = ROR(x,7) ^ ROR(x,18) ^ SHR(x,3)
  - sig1(x) = ROR(x,17) ^ ROR(x,19) ^ SHR(x,10)
  - ROR and SHR are 32-bit rotate-right and logical shift-right.
- End of block: after the word with t=ROUNDS-1 is loaded, the state returns to LOAD with t=0.
  - busy clears on the cycle that last word is handed off (out_valid && out_ready && out_last), unless a new in_valid/in_ready handshake occurs in that same cycle; in that case busy stays 1.
  - The next block's M[0] may be accepted as soon as slot_free. A back-to-back block has no bubble.
- Latency: a word accepted, or computed, in cycle N appears on out_* in cycle N+1.
- There is no combinational path from in_* or out_ready to out_data/out_round.
- Throughput: sustained 1 word/cycle in both phases when out_ready=1 and in_valid=1.
- Buffer hazard: W[t-1] is written at the same clock edge it enters the output register. It is therefore read from the buffer for t+1 with no bypass.

Test Plan:
- Reset, then feed the "abc" padded block: M0=0x61626380, M1..M14=0, M15=0x00000018, with out_ready=1. Required: out_data for t=0..15 equals the inputs, W16=0x61626380, W17=0x000F0000, W18..W63 match the reference model, out_last only at t=63, and 64 handshakes in 64 consecutive cycles after the first accept.
- All-zero block: all 64 outputs equal 0x00000000; out_round increments 0..63 and then wraps to 0.
- Random backpressure (out_ready toggling ~50%) on the abc block: identical sequence to the first test; out_data/out_round are stable while out_valid && !out_ready; in_ready=0 whenever stalled.
- Two back-to-back blocks (abc, then M[i]=i): second block's M0 is accepted in the same cycle as W63 of the first block is handed off; both schedules are correct and busy stays 1 throughout.
- Assert rst at t=30 in EXPAND, then feed the all-zero block: out_valid=0 the cycle after reset; the new block produces 64 zeros with out_round starting at 0.
- ROUNDS=20 build: 20 words are emitted, out_last is asserted at t=19, and the block then accepts the next M0.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: takes 16 message words, streams W[0..ROUNDS-1]
// through a single registered output slot, expanding in place in a 16-word ring.
module sha256_msg_sched #(
  parameter int ROUNDS = 64,
  parameter int RW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [RW-1:0] out_round,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic {LOAD, EXPAND} state_t;

  localparam logic [RW-1:0] LAST_T = RW'(ROUNDS - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] t_q, t_d;
  logic [31:0]   wbuf [16];
  logic          slot_free, accept, step;
  logic [3:0]    ti;
  logic [31:0]   w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = (state_q == LOAD) && slot_free;
    accept    = in_valid && in_ready;
    step      = (state_q == EXPAND) && slot_free;
    ti        = t_q[3:0];
    // Ring offsets wrap mod 16; wbuf[ti] still holds W[t-16] until overwritten
    w_new     = sig1(wbuf[ti - 4'd2]) + wbuf[ti - 4'd7]
              + sig0(wbuf[ti - 4'd15]) + wbuf[ti];
    state_d   = state_q;
    t_d       = t_q;
    if (accept) begin
      t_d = t_q + RW'(1);
      if (ti == 4'd15) state_d = EXPAND;
    end else if (step) begin
      if (t_q == LAST_T) begin
        state_d = LOAD;
        t_d     = '0;
      end else begin
        t_d = t_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      t_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (accept) begin
        out_data  <= in_data;
        out_round <= t_q;
        out_last  <= 1'b0;
        out_valid <= 1'b1;
      end else if (step) begin
        out_data  <= w_new;
        out_round <= t_q;
        out_last  <= (t_q == LAST_T);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A fresh accept in the final hand-off cycle keeps busy asserted
      if (accept)
        busy <= 1'b1;
      else if (out_valid && out_ready && out_last)
        busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      wbuf[ti] <= in_data;
    else if (step)
      wbuf[ti] <= w_new;
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: abc / zero / counting blocks, backpressure,
// back-to-back blocks, mid-block reset, and a reduced-round build.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [31:0] out_data_a;
  logic [5:0]  out_round_a;
  logic        in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [31:0] out_data_b;
  logic [4:0]  out_round_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] msgs [2][16];
  logic [31:0] wexp [2][64];

  always #5 clk = ~clk;

  sha256_msg_sched #(.ROUNDS(64), .RW(6)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_round(out_round_a), .out_last(out_last_a),
    .busy(busy_a));

  sha256_msg_sched #(.ROUNDS(20), .RW(5)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_round(out_round_b), .out_last(out_last_b),
    .busy(busy_b));

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  task automatic build_model();
    for (int b = 0; b < 2; b++) begin
      for (int t = 0; t < 16; t++) wexp[b][t] = msgs[b][t];
      for (int t = 16; t < 64; t++)
        wexp[b][t] = s1(wexp[b][t-2]) + wexp[b][t-7] + s0(wexp[b][t-15]) + wexp[b][t-16];
    end
  endtask

  task automatic set_abc(input int b);
    for (int i = 0; i < 16; i++) msgs[b][i] = 32'h0;
    msgs[b][0]  = 32'h61626380;
    msgs[b][15] = 32'h00000018;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sampled view of whichever DUT is under test
  logic        sel;
  logic        s_in_ready, s_out_valid, s_out_last, s_busy;
  logic [31:0] s_out_data, s_out_round;
  always_comb begin
    s_in_ready  = sel ? in_ready_b  : in_ready_a;
    s_out_valid = sel ? out_valid_b : out_valid_a;
    s_out_last  = sel ? out_last_b  : out_last_a;
    s_busy      = sel ? busy_b      : busy_a;
    s_out_data  = sel ? out_data_b  : out_data_a;
    s_out_round = sel ? {27'd0, out_round_b} : {26'd0, out_round_a};
  end

  task automatic run(input int nblk, input int rounds, input bit bp, input int abort_at);
    int in_idx = 0, out_idx = 0, cyc = 0, first_acc = -1, last_out = -1;
    int total = nblk * rounds;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0, prev_round = '0;
    bit in_fire, out_fire;
    while (out_idx < total && !(abort_at > 0 && out_idx >= abort_at) && cyc < 3000) begin
      @(negedge clk);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (in_idx < 16 * nblk);
      in_data   = in_valid ? msgs[in_idx / 16][in_idx % 16] : 32'h0;
      #1;
      in_fire  = in_valid && s_in_ready;
      out_fire = s_out_valid && out_ready;
      if (prev_stall) begin
        chk("stall_valid", {31'd0, s_out_valid}, 32'd1);
        chk("stall_data", s_out_data, prev_data);
        chk("stall_round", s_out_round, prev_round);
      end
      if (s_out_valid && !out_ready) chk("stall_in_ready", {31'd0, s_in_ready}, 32'd0);
      if (in_idx > 0 && out_idx < total) chk("busy_held", {31'd0, s_busy}, 32'd1);
      if (out_fire) begin
        chk("out_data", s_out_data, wexp[out_idx / rounds][out_idx % rounds]);
        chk("out_round", s_out_round, 32'(out_idx % rounds));
        chk("out_last", {31'd0, s_out_last}, {31'd0, (out_idx % rounds) == rounds - 1});
        out_idx++;
        last_out = cyc;
      end
      if (in_fire) begin
        if (in_idx > 0 && in_idx % 16 == 0 && !bp) begin
          chk("b2b_same_cycle", {31'd0, out_fire}, 32'd1);
          chk("b2b_prev_last", 32'(out_idx), 32'(rounds * (in_idx / 16)));
        end
        if (first_acc < 0) first_acc = cyc;
        in_idx++;
      end
      prev_stall = s_out_valid && !out_ready;
      prev_data  = s_out_data;
      prev_round = s_out_round;
      cyc++;
    end
    if (abort_at == 0) begin
      chk("words_done", 32'(out_idx), 32'(total));
      if (!bp) chk("throughput", 32'(last_out - first_acc), 32'(total));
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("end_busy", {31'd0, s_busy}, 32'd0);
      chk("end_valid", {31'd0, s_out_valid}, 32'd0);
    end
  endtask

  task automatic reset_check();
    chk("rst_valid", {31'd0, s_out_valid}, 32'd0);
    chk("rst_data", s_out_data, 32'h0);
    chk("rst_round", s_out_round, 32'h0);
    chk("rst_last", {31'd0, s_out_last}, 32'd0);
    chk("rst_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_in_ready", {31'd0, s_in_ready}, 32'd1);
  endtask

  initial begin
    sel = 1'b0;
    set_abc(0);
    for (int i = 0; i < 16; i++) msgs[1][i] = 32'(i);
    build_model();
    chk("model_w16", wexp[0][16], 32'h61626380);
    chk("model_w17", wexp[0][17], 32'h000F0000);

    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    #1;
    reset_check();

    run(1, 64, 1'b0, 0);

    for (int i = 0; i < 16; i++) msgs[0][i] = 32'h0;
    build_model();
    run(1, 64, 1'b0, 0);

    set_abc(0);
    build_model();
    run(1, 64, 1'b1, 0);

    run(2, 64, 1'b0, 0);

    run(1, 64, 1'b0, 30);
    @(negedge clk);
    rst_a    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    reset_check();
    for (int i = 0; i < 16; i++) msgs[0][i] = 32'h0;
    build_model();
    run(1, 64, 1'b0, 0);

    rst_a = 1'b1;
    sel   = 1'b1;
    set_abc(0);
    build_model();
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    reset_check();
    run(2, 20, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
